// File: rtl/mem_initiator.sv
// mem_initiator: valid/ready command-to-memory controller, one response per command.
// Build option: define MEM_INITIATOR_WRCHECK_EN to read back and compare every write.
module mem_initiator #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_en,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_valid,
   output logic [7:0]            err_cnt
);
`ifdef MEM_INITIATOR_WRCHECK_EN
   typedef enum logic [1:0] {IDLE, ACCESS, VERIFY, RESP} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif
   state_t state, state_d;
   logic cmd_ready_d, rsp_valid_d, rsp_err_d, mem_en_d, mem_wen_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_d, mem_wdata_d;
   logic [ADDR_WIDTH-1:0] mem_addr_d;
   logic [7:0] err_cnt_d;
   // The mem_* registers double as the command registers: they hold the command through ACCESS/VERIFY.
   // Next-state and next-output logic; every output is a register loaded from these.
   always_comb begin
      state_d     = state;
      cmd_ready_d = 1'b0;
      rsp_valid_d = rsp_valid;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;
      mem_en_d    = 1'b0;
      mem_wen_d   = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      err_cnt_d   = err_cnt;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_d     = ACCESS;
               mem_en_d    = 1'b1;
               mem_wen_d   = cmd_wr;
               mem_addr_d  = cmd_addr;
               mem_wdata_d = cmd_wdata;
            end else begin
               cmd_ready_d = 1'b1;
            end
         end
         ACCESS: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (!mem_wen && mem_valid) ? mem_rdata : '0;
            rsp_err_d   = !mem_wen && !mem_valid;
`ifdef MEM_INITIATOR_WRCHECK_EN
            if (mem_wen) begin
               state_d     = VERIFY;
               rsp_valid_d = 1'b0;
               mem_en_d    = 1'b1;
               mem_addr_d  = mem_addr;
               mem_wdata_d = mem_wdata;
            end
`endif
         end
`ifdef MEM_INITIATOR_WRCHECK_EN
         VERIFY: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_rdata;
            rsp_err_d   = !mem_valid || (mem_rdata != mem_wdata);
         end
`endif
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               cmd_ready_d = 1'b1;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               err_cnt_d   = (rsp_err && err_cnt != 8'hff) ? err_cnt + 8'd1 : err_cnt;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // State and output registers; reset drops any in-flight command.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_en    <= 1'b0;
         mem_wen   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err_cnt   <= '0;
      end else begin
         state     <= state_d;
         cmd_ready <= cmd_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
         mem_en    <= mem_en_d;
         mem_wen   <= mem_wen_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         err_cnt   <= err_cnt_d;
      end
   end
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: table-driven check of mem_initiator against a 16x32 memory model.
module tb_mem_initiator;
`ifdef MEM_INITIATOR_WRCHECK_EN
   localparam bit WC = 1'b1;
`else
   localparam bit WC = 1'b0;
`endif
   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0, force_inv = 1'b0;
   logic [3:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic cmd_ready, rsp_valid, rsp_err, mem_en, mem_wen, mem_valid;
   logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
   logic [3:0] mem_addr;
   logic [7:0] err_cnt;
   logic [31:0] mem [16];
   int total = 0, bad = 0;
   int exp_cnt = 0;

   mem_initiator dut (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_en(mem_en), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Memory model: reset clears it; writing 0xF to address 7 stores a bit-0-corrupted value.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (mem_en && mem_wen) begin
         mem[mem_addr] <= (mem_addr == 4'd7 && mem_wdata == 32'hf) ? 32'he : mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr];
   assign mem_valid = mem_en && !mem_wen && !force_inv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                         input int hold, input logic inv, input logic [31:0] erd, input logic eerr);
      int n;
      n = 0;
      while (!cmd_ready && n < 20) begin tick(); n++; end
      chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; force_inv = inv;
      tick();
      cmd_valid = 1'b0; cmd_wr = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
      chk("access_en", {31'b0, mem_en}, 32'd1);
      chk("access_wen", {31'b0, mem_wen}, {31'b0, wr});
      chk("access_addr", {28'b0, mem_addr}, {28'b0, addr});
      chk("access_wdata", mem_wdata, wr ? wdata : mem_wdata);
      chk("access_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      n = 1;
      while (!rsp_valid && n < 10) begin
         tick();
         n++;
         if (WC && wr && n == 2) begin
            chk("verify_en", {31'b0, mem_en}, 32'd1);
            chk("verify_wen", {31'b0, mem_wen}, 32'd0);
            chk("verify_addr", {28'b0, mem_addr}, {28'b0, addr});
         end
      end
      force_inv = 1'b0;
      chk("rsp_latency", n, (WC && wr) ? 3 : 2);
      for (int h = 0; h < hold; h++) begin
         chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("hold_rdata", rsp_rdata, erd);
         chk("hold_err", {31'b0, rsp_err}, {31'b0, eerr});
         chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
         chk("hold_mem_en", {31'b0, mem_en}, 32'd0);
         tick();
      end
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_rdata", rsp_rdata, erd);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, eerr});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      if (eerr) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      chk("after_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("after_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("err_cnt", {24'b0, err_cnt}, exp_cnt);
   endtask

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      int          hold;
      logic        inv;
      logic [31:0] erd;
      logic        eerr;
   } vec_t;
   vec_t v [8];

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd0);
      chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
      chk({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
      chk({tag, "_mem_wen"}, {31'b0, mem_wen}, 32'd0);
      chk({tag, "_mem_addr"}, {28'b0, mem_addr}, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_err_cnt"}, {24'b0, err_cnt}, 32'd0);
   endtask

   initial begin
      v[0] = '{1'b1, 4'd3, 32'hdeadbeef, 0, 1'b0, WC ? 32'hdeadbeef : 32'h0, 1'b0};
      v[1] = '{1'b0, 4'd3, 32'h0,        0, 1'b0, 32'hdeadbeef,                1'b0};
      v[2] = '{1'b0, 4'd3, 32'h0,        5, 1'b0, 32'hdeadbeef,                1'b0};
      v[3] = '{1'b0, 4'd3, 32'h0,        2, 1'b1, 32'h0,                       1'b1};
      v[4] = '{1'b1, 4'd15, 32'ha5a5_5a5a, 1, 1'b0, WC ? 32'ha5a5_5a5a : 32'h0, 1'b0};
      v[5] = '{1'b1, 4'd0, 32'h0000_0001, 0, 1'b0, WC ? 32'h1 : 32'h0,        1'b0};
      v[6] = '{1'b0, 4'd15, 32'h0,       0, 1'b0, 32'ha5a5_5a5a,               1'b0};
      v[7] = '{1'b0, 4'd9, 32'h0,        3, 1'b0, 32'h0,                       1'b0};
      #2 rstn = 1'b0;
      #1 chk_reset_outputs("rst_async");
      tick();
      tick();
      chk_reset_outputs("rst_held");
      #3 rstn = 1'b1;
      tick();
      chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rel_err_cnt", {24'b0, err_cnt}, 32'd0);
      for (int i = 0; i < 8; i++)
         do_cmd(v[i].wr, v[i].addr, v[i].wdata, v[i].hold, v[i].inv, v[i].erd, v[i].eerr);
      if (WC) do_cmd(1'b1, 4'd7, 32'hf, 1, 1'b0, 32'he, 1'b1);
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd5; cmd_wdata = 32'h1234_5678;
      tick();
      cmd_valid = 1'b0;
      chk("mid_access_en", {31'b0, mem_en}, 32'd1);
      #2 rstn = 1'b0;
      #1 chk_reset_outputs("mid_rst");
      exp_cnt = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
      end
      rsp_ready = 1'b0;
      #3 rstn = 1'b1;
      tick();
      chk("mid_rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("mid_rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      do_cmd(1'b0, 4'd5, 32'h0, 0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 257; i++) do_cmd(1'b0, 4'd1, 32'h0, 0, 1'b1, 32'h0, 1'b1);
      chk("err_cnt_sat", {24'b0, err_cnt}, 32'd255);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_initiator.md
# mem_initiator

Initiator-side controller for the 16x32 single-port memory. It accepts read and write commands on a valid/ready command channel and drives the memory's en/wen/Addr/Data_in pins. It captures Data_out, qualified by Valid, and returns exactly one response per command on a valid/ready response channel. It sits between a bus-facing agent and the memory, and is the only block that drives the memory pins.

## Interface
- ADDR_WIDTH, 4: memory address width.
- DATA_WIDTH, 32: memory data width.

- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_wr  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  target address.
- cmd_wdata  input  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data (reads), readback data (checked writes), otherwise 0.
- rsp_err  output  1  access error for this response.
- mem_en  output  1  memory enable.
- mem_wen  output  1  memory write enable.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory Data_out.
- mem_valid  input  1  memory Valid.
- err_cnt  output  8  saturating count of responses issued with rsp_err=1.

## Operation
- FSM states: IDLE, ACCESS, VERIFY (only with checking compiled in), RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register wr/addr/wdata, go to ACCESS.
- ACCESS: mem_en=1, mem_wen=wr, mem_addr/mem_wdata from the command registers.
  - Read: at the end of the cycle, if mem_valid=1, capture mem_rdata into rsp_rdata with rsp_err=0. Otherwise rsp_rdata=0 and rsp_err=1. Go to RESP.
  - Write: the memory commits at the end of the cycle. Go to RESP with rsp_rdata=0 and rsp_err=0, or go to VERIFY when checking is enabled.
- RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable until rsp_ready=1, then go to IDLE. mem_en=0.
- cmd_ready=0 in every state except IDLE. There is no command buffering, so at most one command is in flight.
- All outputs are registered. mem_en, mem_wen, mem_addr and mem_wdata are 0 outside ACCESS and VERIFY.
- err_cnt increments by 1 on each rsp_valid&rsp_ready handshake with rsp_err=1, and saturates at 255.
- Reset, including assertion mid-operation: state goes to IDLE and the in-flight command is dropped with no response.
  - Outputs during and after reset: cmd_ready=0 while rstn=0, then 1 in IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0, err_cnt=0.

## Timing
- The command handshake occurs in cycle N.
- Cycle N+1: ACCESS, mem_en=1.
- Cycle N+2: rsp_valid=1 (reads, and unchecked writes).
- Checked write: cycle N+2 is VERIFY; rsp_valid=1 from cycle N+3.
- The response handshake occurs in cycle M. The block is in IDLE with cmd_ready=1 in cycle M+1.
- Peak throughput: 1 command per 3 cycles (4 cycles with checked writes).
- cmd_* inputs are sampled only at the handshake edge. Later changes have no effect.

## Configuration
- Macro MEM_INITIATOR_WRCHECK_EN.
- Defined: every write is followed by VERIFY. VERIFY drives mem_en=1, mem_wen=0, same address, for one cycle.
  - rsp_rdata = mem_rdata.
  - rsp_err=1 if mem_valid=0 or mem_rdata≠the registered wdata.
- Undefined: the VERIFY state is absent. Writes go ACCESS→RESP with rsp_rdata=0, rsp_err=0.

## Test plan
- Reset: rstn low → all outputs 0. Release → cmd_ready=1 on the first clock, err_cnt=0.
- Write 0xDEADBEEF to addr 3, then read addr 3:
  - Write response: rsp_rdata=0 (or 0xDEADBEEF with WRCHECK), rsp_err=0.
  - Read response: rsp_valid exactly 2 cycles after the read handshake, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Backpressure: read addr 3 with rsp_ready held low for 5 cycles → rsp_valid, rsp_rdata and rsp_err stable, and cmd_ready=0 throughout. Raise rsp_ready → cmd_ready=1 the next cycle.
- Invalid read: force mem_valid=0 during ACCESS → rsp_err=1, rsp_rdata=0, err_cnt=1 after the handshake.
- Reset mid-operation: assert rstn during ACCESS of a write of 0x12345678 to addr 5 → no response issued. A subsequent read of addr 5 returns 0 (memory also reset).
- WRCHECK only: the memory model corrupts bit 0 on the write of 0x0000000F to addr 7 → rsp_rdata=0x0000000E, rsp_err=1, err_cnt increments.
